// File: rtl/inv_sqrt_iter_pkg.sv
// -----------------------------------------------------------------------------
// inv_sqrt_iter_pkg
// Shared fixed-point math definitions for the inverse-square-root datapath.
//   fixed              : signed FULL_WIDTH value with FRAC_WIDTH fraction bits
//   INV_SQRT_ERR_VAL   : result returned for operands <= 0 (max positive fixed)
//   FIXED_THREE_HALVES : the 1.5 constant of the Newton step
//   inv_sqrt_state_t   : controller states of inv_sqrt_iter
// -----------------------------------------------------------------------------
package inv_sqrt_iter_pkg;

  localparam int FULL_WIDTH = 32;
  localparam int FRAC_WIDTH = 16;
  localparam int LEAD_W     = $clog2(FULL_WIDTH);

  typedef logic signed [FULL_WIDTH-1:0] fixed;

  localparam fixed INV_SQRT_ERR_VAL   = {1'b0, {(FULL_WIDTH-1){1'b1}}};
  localparam fixed FIXED_THREE_HALVES = fixed'(3) <<< (FRAC_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } inv_sqrt_state_t;

endpackage

// File: rtl/inv_sqrt_seed.sv
// -----------------------------------------------------------------------------
// inv_sqrt_seed
// Combinational power-of-two seed for the Newton iteration.
//   x      : operand (fixed)
//   y0     : 2^-ceil(e/2) as fixed, e = leading-one index - FRAC_WIDTH
//   nonpos : x is zero or negative (y0 is then meaningless)
// -----------------------------------------------------------------------------
module inv_sqrt_seed
  import inv_sqrt_iter_pkg::*;
(
  input  fixed x,
  output fixed y0,
  output logic nonpos
);

  logic [LEAD_W-1:0] lead_idx;
  int                exp_e;
  int                shift;

  // The seed keeps y0*sqrt(x) within [0.707, 1.414), well inside the
  // sqrt(3) convergence bound. (e+1)>>>1 is ceil(e/2) for negative e too.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < FULL_WIDTH; i++) begin
      if (x[i]) lead_idx = LEAD_W'(i);
    end
    exp_e  = int'(lead_idx) - FRAC_WIDTH;
    shift  = FRAC_WIDTH - ((exp_e + 1) >>> 1);
    nonpos = x[FULL_WIDTH-1] || (x == '0);
    y0     = nonpos ? '0 : (fixed'(1) << shift);
  end

endmodule

// File: rtl/inv_sqrt_stage.sv
// -----------------------------------------------------------------------------
// inv_sqrt_stage
// One Newton step for 1/sqrt(x):  y_next = y * (1.5 - (x*y*y)/2).
// The result appears STAGE_LAT clocks after x and y become stable.
//   clk, rst : clock, active-high asynchronous reset of the result pipeline
//   x, y     : operand and current guess (fixed)
//   y_next   : refined guess (fixed)
// -----------------------------------------------------------------------------
module inv_sqrt_stage
  import inv_sqrt_iter_pkg::*;
#(
  parameter int STAGE_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  fixed x,
  input  fixed y,
  output fixed y_next
);

  fixed xy;
  fixed xyy;
  fixed corr;
  fixed y_comb;
  fixed pipe [STAGE_LAT];

  // x*y is formed first so small x with a large seed never overflows y*y.
  mul_fixed u_mul_xy  (.a(x),  .b(y),    .p(xy));
  mul_fixed u_mul_xyy (.a(xy), .b(y),    .p(xyy));
  assign corr = FIXED_THREE_HALVES - (xyy >>> 1);
  mul_fixed u_mul_out (.a(y),  .b(corr), .p(y_comb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= y_comb;
      for (int i = 1; i < STAGE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y_next = pipe[STAGE_LAT-1];

endmodule

// File: rtl/mul_fixed.sv
// -----------------------------------------------------------------------------
// mul_fixed
// Combinational signed fixed-point multiply, truncated back to the fixed type.
//   a, b : fixed operands
//   p    : (a * b) >> FRAC_WIDTH, arithmetic shift, upper bits discarded
// -----------------------------------------------------------------------------
module mul_fixed
  import inv_sqrt_iter_pkg::*;
(
  input  fixed a,
  input  fixed b,
  output fixed p
);

  logic signed [2*FULL_WIDTH-1:0] prod;

  // Sign-extend both operands so the low 2*FULL_WIDTH bits of the product
  // equal the true signed product.
  assign prod = $signed({{FULL_WIDTH{a[FULL_WIDTH-1]}}, a} *
                        {{FULL_WIDTH{b[FULL_WIDTH-1]}}, b});
  assign p    = fixed'(prod >>> FRAC_WIDTH);

endmodule

// File: rtl/inv_sqrt_iter.sv
// -----------------------------------------------------------------------------
// inv_sqrt_iter
// Iterative 1/sqrt(x): seeds from the leading one, then recirculates one
// inv_sqrt_stage ITERS times. One operand in flight.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake, x_in sampled on the handshake
//   x_in                : operand (fixed)
//   out_valid, out_ready: result handshake
//   y_out               : 1/sqrt(x) (fixed), INV_SQRT_ERR_VAL on error
//   err                 : operand was <= 0, qualified by out_valid
// -----------------------------------------------------------------------------
module inv_sqrt_iter
  import inv_sqrt_iter_pkg::*;
#(
  parameter int ITERS     = 4,
  parameter int STAGE_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  fixed x_in,
  output logic out_valid,
  input  logic out_ready,
  output fixed y_out,
  output logic err
);

  localparam int ITER_W = $clog2(ITERS + 1);
  localparam int WAIT_W = $clog2(STAGE_LAT + 2);

  inv_sqrt_state_t   state;
  fixed              x_r;
  fixed              y_r;
  fixed              y_seed;
  fixed              y_next;
  logic              seed_nonpos;
  logic [ITER_W-1:0] iter_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;
  logic              iter_last;

  inv_sqrt_seed u_seed (
    .x      (x_r),
    .y0     (y_seed),
    .nonpos (seed_nonpos)
  );

  inv_sqrt_stage #(.STAGE_LAT(STAGE_LAT)) u_stage (
    .clk    (clk),
    .rst    (!rst_n),
    .x      (x_r),
    .y      (y_r),
    .y_next (y_next)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // x_r/y_r stay put for STAGE_LAT+1 cycles, so the stage output on the
  // last wait cycle reflects the current guess rather than a stale one.
  assign wait_last = (wait_cnt == WAIT_W'(STAGE_LAT));
  assign iter_last = (iter_cnt == ITER_W'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_r      <= '0;
      y_r      <= '0;
      y_out    <= '0;
      err      <= 1'b0;
      iter_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= x_in;
            state <= SEED;
          end
        end
        SEED: begin
          iter_cnt <= '0;
          wait_cnt <= '0;
          if (seed_nonpos) begin
            y_out <= INV_SQRT_ERR_VAL;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            y_r   <= y_seed;
            err   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (wait_last) begin
            wait_cnt <= '0;
            y_r      <= y_next;
            iter_cnt <= iter_cnt + ITER_W'(1);
            if (iter_last) begin
              y_out <= y_next;
              state <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
